vga_fb_arbiter: RTL

VGA_FB_ARBITER -- requirements
Module: vga_fb_arbiter

---
 rtl/vga_fb_arbiter.sv | 130 +++++++++++++
 1 files changed

// File: rtl/vga_fb_arbiter.sv
// Framebuffer RAM port arbiter: display reads, clear engine, two writers.
// Ports: clk_vga/rst_n, vga_xpos/ypos in, vga_data out, ram_* single port,
//        wr_req/addr/data/ack for engines A and B, clr_req/color/busy/done.
module vga_fb_arbiter #(
    parameter int FB_W_LOG2  = 8,
    parameter int FB_H       = 192,
    parameter int SCALE_LOG2 = 2
) (
    input  logic        clk_vga,
    input  logic        rst_n,
    input  logic [9:0]  vga_xpos,
    input  logic [9:0]  vga_ypos,
    output logic [11:0] vga_data,
    output logic [15:0] ram_addr,
    output logic [11:0] ram_wdata,
    output logic        ram_we,
    input  logic [11:0] ram_rdata,
    input  logic        wr_req_a,
    input  logic        wr_req_b,
    input  logic [15:0] wr_addr_a,
    input  logic [15:0] wr_addr_b,
    input  logic [11:0] wr_data_a,
    input  logic [11:0] wr_data_b,
    output logic        wr_ack_a,
    output logic        wr_ack_b,
    input  logic        clr_req,
    input  logic [11:0] clr_color,
    output logic        clr_busy,
    output logic        clr_done
);

    localparam logic [15:0] LAST =
        16'((1 << FB_W_LOG2) * FB_H - 1);
    localparam logic [15:0] XMASK =
        16'((1 << FB_W_LOG2) - 1);

    typedef enum logic {IDLE, CLEAR} state_t;

    state_t      state;
    logic [15:0] clr_cnt;
    logic [11:0] clr_col;
    logic        disp_d1;
    logic        disp_d2;
    logic        rr_b;

    logic        disp;
    logic [9:0]  xm;
    logic [9:0]  ym;
    logic [15:0] rd_addr;
    logic        elig_a;
    logic        elig_b;
    logic        grant;
    logic        pick_b;
    logic [15:0] g_addr;
    logic [11:0] g_data;

    always_comb begin
        disp    = (vga_xpos != 10'd0) && (vga_ypos != 10'd0);
        xm      = (vga_xpos - 10'd1) >> SCALE_LOG2;
        ym      = (vga_ypos - 10'd1) >> SCALE_LOG2;
        rd_addr = ({6'd0, ym} << FB_W_LOG2)
                | ({6'd0, xm} & XMASK);
        // a requester still seeing its ack is holding the old request
        elig_a  = wr_req_a & ~wr_ack_a;
        elig_b  = wr_req_b & ~wr_ack_b;
        grant   = elig_a | elig_b;
        pick_b  = elig_b & (~elig_a | rr_b);
        g_addr  = pick_b ? wr_addr_b : wr_addr_a;
        g_data  = pick_b ? wr_data_b : wr_data_a;
    end

    always_ff @(posedge clk_vga or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            clr_cnt   <= '0;
            clr_col   <= '0;
            disp_d1   <= 1'b0;
            disp_d2   <= 1'b0;
            rr_b      <= 1'b0;
            vga_data  <= '0;
            ram_addr  <= '0;
            ram_wdata <= '0;
            ram_we    <= 1'b0;
            wr_ack_a  <= 1'b0;
            wr_ack_b  <= 1'b0;
            clr_busy  <= 1'b0;
            clr_done  <= 1'b0;
        end else begin
            wr_ack_a <= 1'b0;
            wr_ack_b <= 1'b0;
            clr_done <= 1'b0;
            disp_d1  <= disp;
            disp_d2  <= disp_d1;
            vga_data <= disp_d2 ? ram_rdata : 12'h000;

            if (state == IDLE && clr_req) begin
                state    <= CLEAR;
                clr_col  <= clr_color;
                clr_cnt  <= '0;
                clr_busy <= 1'b1;
            end

            if (disp) begin
                ram_we   <= 1'b0;
                ram_addr <= rd_addr;
            end else if (state == CLEAR) begin
                ram_we    <= 1'b1;
                ram_addr  <= clr_cnt;
                ram_wdata <= clr_col;
                clr_cnt   <= clr_cnt + 16'd1;
                if (clr_cnt == LAST) begin
                    state    <= IDLE;
                    clr_busy <= 1'b0;
                    clr_done <= 1'b1;
                end
            end else if (!clr_req && grant) begin
                ram_addr  <= g_addr;
                ram_wdata <= g_data;
                // out-of-range writes are acknowledged but dropped
                ram_we    <= (g_addr <= LAST);
                wr_ack_a  <= ~pick_b;
                wr_ack_b  <= pick_b;
                rr_b      <= ~pick_b;
            end else begin
                ram_we <= 1'b0;
            end
        end
    end

endmodule
